// File: rtl/bit_serial_frame_io.sv
// Parallel-side endpoint for a bit-serial multiplier. It takes an operand pair, streams it
// out LSB-first with framing, and collects the serial product back into a parallel word.
module bit_serial_frame_io #(
  parameter int K         = 8,
  parameter int P_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K-1:0]   in_a,
  input  logic [K-1:0]   in_b,
  output logic           x,
  output logic           y,
  output logic           first_bit,
  output logic           last_bit,
  input  logic           p,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*K-1:0] out_product
);

  localparam int W  = 2 * K;
  localparam int SW = $clog2(W);
  localparam int DW = $clog2(W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [SW-1:0] LAST_SLOT     = SW'(W - 1);
  localparam logic [SW-1:0] PRE_LAST_SLOT = SW'(W - 2);
  localparam logic [DW-1:0] LAT           = DW'(P_LATENCY);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [SW-1:0] capCnt_q, capCnt_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [W-1:0]  aSh_q, aSh_d;
  logic [W-1:0]  bSh_q, bSh_d;
  logic [W-2:0]  prodSh_q, prodSh_d;
  logic [W-1:0]  product_q, product_d;
  logic          x_q, x_d;
  logic          y_q, y_d;
  logic          first_q, first_d;
  logic          last_q, last_d;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    capCnt_d  = capCnt_q;
    delay_d   = delay_q;
    aSh_d     = aSh_q;
    bSh_d     = bSh_q;
    prodSh_d  = prodSh_q;
    product_d = product_q;
    x_d       = 1'b0;
    y_d       = 1'b0;
    first_d   = 1'b0;
    last_d    = 1'b0;

    // Slot 0 is driven straight from the inputs, so the shift registers keep bits 1 and up.
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          aSh_d    = {{K{1'b0}}, in_a} >> 1;
          bSh_d    = {{K{1'b0}}, in_b} >> 1;
          x_d      = in_a[0];
          y_d      = in_b[0];
          first_d  = 1'b1;
          slot_d   = '0;
          capCnt_d = '0;
          delay_d  = '0;
          prodSh_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (slot_q != LAST_SLOT) begin
          x_d    = aSh_q[0];
          y_d    = bSh_q[0];
          aSh_d  = aSh_q >> 1;
          bSh_d  = bSh_q >> 1;
          last_d = (slot_q == PRE_LAST_SLOT);
          slot_d = slot_q + 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DRAIN;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Captures lag the slots by P_LATENCY cycles and run on into DRAIN; the last one ends the frame.
    if (state_q == SHIFT || state_q == DRAIN) begin
      if (delay_q != LAT) begin
        delay_d = delay_q + 1'b1;
      end else begin
        prodSh_d = {p, prodSh_q[W-2:1]};
        capCnt_d = capCnt_q + 1'b1;
        if (capCnt_q == LAST_SLOT) begin
          product_d = {p, prodSh_q};
          state_d   = DONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      capCnt_q  <= '0;
      delay_q   <= '0;
      aSh_q     <= '0;
      bSh_q     <= '0;
      prodSh_q  <= '0;
      product_q <= '0;
      x_q       <= 1'b0;
      y_q       <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      capCnt_q  <= capCnt_d;
      delay_q   <= delay_d;
      aSh_q     <= aSh_d;
      bSh_q     <= bSh_d;
      prodSh_q  <= prodSh_d;
      product_q <= product_d;
      x_q       <= x_d;
      y_q       <= y_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_product = product_q;
  assign x           = x_q;
  assign y           = y_q;
  assign first_bit   = first_q;
  assign last_bit    = last_q;

endmodule
